// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC, single-cycle imem requests, small {inst, pc} queue to ID.
// Define FETCH_PREDECODE_EN to add per-entry branch predecode and the br_hint_o output.
module fetch_unit #(
  parameter int unsigned          W_INST   = 32,
  parameter int unsigned          W_PC     = 32,
  parameter logic [W_PC-1:0]      PC_RESET = '0,
  parameter int unsigned          Q_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [W_PC-1:0]   redirect_pc_i,
  output logic              imem_req_o,
  output logic [W_PC-1:0]   imem_addr_o,
  input  logic [W_INST-1:0] imem_data_i,
  output logic              valid_o,
  output logic [W_INST-1:0] inst_o,
  output logic [W_PC-1:0]   pc_o
`ifdef FETCH_PREDECODE_EN
  ,
  output logic              br_hint_o
`endif
);

  localparam int unsigned PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CW = $clog2(Q_DEPTH + 1);
  localparam int unsigned OW = CW + 1;

  logic [W_PC-1:0]   fetch_pc;
  logic              inflight;
  logic [W_PC-1:0]   inflight_pc;
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [W_INST-1:0] inst_mem [Q_DEPTH];
  logic [W_PC-1:0]   pc_mem   [Q_DEPTH];

  logic              pop;
  logic              push;
  logic [OW-1:0]     occ;

  assign valid_o     = (count != '0);
  assign pop         = valid_o & ~stall_i;
  assign push        = inflight & ~redirect_i;
  assign imem_addr_o = fetch_pc;

  // Occupancy after this cycle's pop, counting the word already in flight, so
  // every requested word is guaranteed a free slot when it returns.
  assign occ        = OW'(count) + OW'(inflight) - OW'(pop);
  assign imem_req_o = ~rst & ~redirect_i & (occ < OW'(Q_DEPTH));

  assign inst_o = valid_o ? inst_mem[head] : '0;
  assign pc_o   = valid_o ? pc_mem[head]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= PC_RESET;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect_i) begin
      // Flush wins over stall, pop and push; the returning word is dropped.
      fetch_pc <= redirect_pc_i;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      inflight <= imem_req_o;
      if (imem_req_o) begin
        fetch_pc    <= fetch_pc + W_PC'(4);
        inflight_pc <= fetch_pc;
      end
      if (push) begin
        tail <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[tail] <= imem_data_i;
      pc_mem[tail]   <= inflight_pc;
    end
  end

`ifdef FETCH_PREDECODE_EN
  logic hint_mem [Q_DEPTH];
  logic hint_in;

  // Branch group is opcode 7'b00111xx.
  assign hint_in   = (imem_data_i[W_INST-1:W_INST-5] == 5'b00111);
  assign br_hint_o = valid_o & hint_mem[head];

  always_ff @(posedge clk) begin
    if (push) begin
      hint_mem[tail] <= hint_in;
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage feeding the ID decoder. Generates a sequential byte PC, issues requests to a synchronous single-cycle instruction memory, buffers returned instructions in a small queue, and presents them to ID as `inst_o` with `valid_o`. ID throttles it through `stall_i`, which is driven by ID's `stall_o`. Branch resolution redirects it through `redirect_i`.

## Interface
- `W_INST`, 32, instruction width; the opcode is `inst[W_INST-1:W_INST-7]`.
- `W_PC`, 32, PC / byte-address width.
- `PC_RESET`, 32'h0, first fetch address after reset.
- `Q_DEPTH`, 2, instruction queue entries; must be a power of two and ≥2.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall_i`  in  1  from ID `stall_o`; while high, the current head is not consumed.
- `redirect_i`  in  1  branch/redirect request; flushes the queue and reloads the PC.
- `redirect_pc_i`  in  W_PC  redirect target byte address.
- `imem_req_o`  out  1  instruction memory read request.
- `imem_addr_o`  out  W_PC  request byte address.
- `imem_data_i`  in  W_INST  read data, valid exactly one cycle after `imem_req_o`.
- `valid_o`  out  1  `inst_o` / `pc_o` hold a valid instruction.
- `inst_o`  out  W_INST  head-of-queue instruction.
- `pc_o`  out  W_PC  byte address of `inst_o`.
- `br_hint_o`  out  1  head is a branch-class opcode (only with `FETCH_PREDECODE_EN`).

## Operation
- **State:**
  - `fetch_pc` register, reset to `PC_RESET`.
  - `inflight` flag, set when a request was issued last cycle.
  - Circular queue of {inst, pc} with head/tail pointers and `count` (0..Q_DEPTH).
- `imem_addr_o = fetch_pc`.
- **Pop and request:**
  - `pop = valid_o & ~stall_i`.
  - `imem_req_o = ~rst & ~redirect_i & ((count + inflight - pop) < Q_DEPTH)`.
  - This guarantees every returned word has a free slot.
- **On a request:** `fetch_pc <= fetch_pc + 4`, wrapping modulo 2^W_PC. The issued address is remembered as `inflight_pc`.
- **Response:** when `inflight` is high and `redirect_i` is low, push {`imem_data_i`, `inflight_pc`} at the tail.
- **Head:** `valid_o = (count != 0)`. `inst_o` and `pc_o` show the head entry when valid and are forced to 0 when `valid_o` is low.
- **Stall:** while `stall_i` is high, the head and outputs are held unchanged. Pushes continue until the queue is full. No instruction is dropped or duplicated.
- **Same-cycle push and pop:** `count` is unchanged and both pointers advance.
- **Redirect in cycle N:**
  - The queue is emptied: `count <= 0` and pointers are reset.
  - The response arriving in cycle N (from a cycle N-1 request) is discarded.
  - No request is issued in cycle N.
  - `fetch_pc <= redirect_pc_i`.
  - Redirect takes priority over stall, pop and push.
- Back-to-back redirects: the last one wins. Each one flushes again.
- `redirect_pc_i` is used as given; the low 2 bits are not forced. Alignment is the producer's responsibility.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronously). Any in-flight response is ignored.

## Timing
- **Reset values:**
  - `imem_req_o` = 0.
  - `imem_addr_o` = `PC_RESET`.
  - `valid_o`, `inst_o`, `pc_o` and `br_hint_o` = 0.
- **From reset:**
  - First request in the first cycle after `rst` deasserts (cycle 0).
  - Data on `imem_data_i` in cycle 1.
  - `valid_o` first high in cycle 2.
- **Latency:**
  - Request to `valid_o` is 2 cycles.
  - Redirect in cycle N: request to the target in N+1, target instruction on `valid_o` in N+3.
- **Throughput:** 1 instruction/cycle sustained with `stall_i` low, for Q_DEPTH=2.
- **Stall release:** a stall releasing in cycle M presents the next queued instruction in cycle M+1, with no bubble if the queue holds ≥2 entries.

## Configuration
- **`FETCH_PREDECODE_EN` defined:**
  - A predecode bit is computed from opcode bits of `imem_data_i` at push and stored per queue entry.
  - `br_hint_o` is 1 when the head is valid and its opcode is in 7'b0011100–7'b0011111, the branch group.
  - Otherwise `br_hint_o` is 0. It is cleared by flush and reset.
- **Undefined:**
  - The `br_hint_o` port is absent.
  - No predecode storage exists.
  - All other behaviour is identical.

## Test plan
- **Reset then free run:** `PC_RESET`=0, `stall_i`=0, memory returns `addr|32'hA000_0000`.
  - Expect `valid_o` from cycle 2.
  - Expect `pc_o` 0,4,8,…, one per cycle, with `inst_o` = A000_0000, A000_0004, ….
- **Stall hold:** raise `stall_i` for 4 cycles while `pc_o`=8.
  - Expect `pc_o`/`inst_o` held at 8, `imem_req_o` low once count+inflight=2, and no missing or repeated PC after release (next `pc_o`=12).
- **Redirect:** assert `redirect_i` with `redirect_pc_i`=32'h100 in cycle N while streaming.
  - Expect `imem_req_o`=0 in N, `imem_addr_o`=32'h100 in N+1, `valid_o`=0 in N+1..N+2, then `pc_o`=32'h100 in N+3 and 32'h104 in N+4.
- **Redirect during stall:** with a full queue and `stall_i`=1, pulse `redirect_i` to 32'h40.
  - Expect the queue flushed (`valid_o`=0 next cycle).
  - Expect the first valid `pc_o`=32'h40.
- **PC wrap:** `PC_RESET`=32'hFFFF_FFF8.
  - Expect `pc_o` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- **Predecode (macro on):** memory returns opcodes 7'b0011101 then 7'b0000001.
  - Expect `br_hint_o`=1 with the first, 0 with the second.
  - Assert `rst` mid-stream: all outputs 0 immediately.
